// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and strobe sequencer for a single-port byte memory
//   clk, rst (async, active low)
//   r0_*/r1_* : req/we/addr/wdata/size in; gnt/done/err/rdata out (registered)
//   m_*       : latched addr/wdata/size, wen, read/write strobes out; m_rdata in
//   busy      : state is not IDLE
module mem_arbiter #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r1_req,
  input  logic        r0_we,
  input  logic        r1_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r0_wdata,
  input  logic [31:0] r1_wdata,
  input  logic [3:0]  r0_size,
  input  logic [3:0]  r1_size,
  output logic        r0_gnt,
  output logic        r1_gnt,
  output logic        r0_done,
  output logic        r1_done,
  output logic        r0_err,
  output logic        r1_err,
  output logic [31:0] r0_rdata,
  output logic [31:0] r1_rdata,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_size,
  output logic        m_wen,
  output logic        m_read,
  output logic        m_write,
  input  logic [31:0] m_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic last, sel, we, win, go, mis, last_beat;
  // with both requesting, the one not served last wins
  assign win = (r0_req && r1_req) ? ~last : r1_req;
  assign go = state == IDLE && (r0_req || r1_req);
  // m_addr/m_size hold the latched request; byte sizes take priority over half sizes
  assign mis = (m_size[3] | m_size[2]) ? 1'b0 : (m_size[1] | m_size[0]) ? m_addr[0] : |m_addr[1:0];
  assign last_beat = we || cnt == CW'(LAT - 1);
  assign busy = state != IDLE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = go ? SETUP : IDLE;
      SETUP:   nxt = mis ? DONE : ACCESS;
      ACCESS:  nxt = last_beat ? DONE : ACCESS;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= 1'b1;
      sel <= 1'b0;
      we <= 1'b0;
      cnt <= '0;
      m_addr <= '0;
      m_wdata <= '0;
      m_size <= '0;
      m_wen <= 1'b0;
      m_read <= 1'b0;
      m_write <= 1'b0;
      r0_gnt <= 1'b0;
      r1_gnt <= 1'b0;
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      r0_err <= 1'b0;
      r1_err <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      if (go) begin
        sel <= win;
        last <= win;
        we <= win ? r1_we : r0_we;
        m_addr <= win ? r1_addr : r0_addr;
        m_wdata <= win ? r1_wdata : r0_wdata;
        m_size <= win ? r1_size : r0_size;
      end
      r0_gnt <= go && !win;
      r1_gnt <= go && win;
      m_wen <= go ? (win ? r1_we : r0_we) : nxt == ACCESS && we;
      m_read <= nxt == ACCESS && !we;
      m_write <= nxt == ACCESS && we;
      cnt <= state == ACCESS ? cnt + 1'b1 : '0;
      r0_done <= nxt == DONE && !sel;
      r1_done <= nxt == DONE && sel;
      r0_err <= state == SETUP && mis && !sel;
      r1_err <= state == SETUP && mis && sel;
      if (state == ACCESS && !we && last_beat && !sel) r0_rdata <= m_rdata;
      if (state == ACCESS && !we && last_beat && sel) r1_rdata <= m_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a byte-memory model
module tb_mem_arbiter;
  localparam int LAT = 1;
  typedef struct {int p; logic e; logic [31:0] rd;} exp_t;
  logic clk = 0, rst = 0, load = 1;
  logic [1:0] req = 0, we = 0, gnt, done, err;
  logic [1:0][31:0] addr = 0, wdata = 0, rdata, shadow = 0;
  logic [1:0][3:0] size = 0;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0] m_size;
  logic m_wen, m_read, m_write, busy;
  logic [7:0] mem [0:511];
  logic [7:0] b0, b1, b2, b3;
  exp_t sb[$];
  int checks = 0, errors = 0;

  mem_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .r0_req(req[0]), .r1_req(req[1]), .r0_we(we[0]), .r1_we(we[1]),
    .r0_addr(addr[0]), .r1_addr(addr[1]), .r0_wdata(wdata[0]), .r1_wdata(wdata[1]),
    .r0_size(size[0]), .r1_size(size[1]),
    .r0_gnt(gnt[0]), .r1_gnt(gnt[1]), .r0_done(done[0]), .r1_done(done[1]),
    .r0_err(err[0]), .r1_err(err[1]), .r0_rdata(rdata[0]), .r1_rdata(rdata[1]),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size), .m_wen(m_wen),
    .m_read(m_read), .m_write(m_write), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // memory model: little endian, b > bu > h > hu priority, sign/zero extension
  always_comb begin
    b0 = mem[m_addr[8:0]];
    b1 = mem[m_addr[8:0] + 9'd1];
    b2 = mem[m_addr[8:0] + 9'd2];
    b3 = mem[m_addr[8:0] + 9'd3];
    m_rdata = m_size[3] ? {{24{b0[7]}}, b0} : m_size[2] ? {24'b0, b0} :
              m_size[1] ? {{16{b1[7]}}, b1, b0} : m_size[0] ? {16'b0, b1, b0} : {b3, b2, b1, b0};
  end

  initial forever begin
    @(posedge clk);
    if (load) begin
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      mem[9'h040] = 8'hEF; mem[9'h041] = 8'hBE; mem[9'h042] = 8'hAD; mem[9'h043] = 8'hDE;
      mem[9'h080] = 8'h78; mem[9'h081] = 8'h56; mem[9'h082] = 8'h34; mem[9'h083] = 8'h12;
    end else if (m_write && m_wen) begin
      mem[m_addr[8:0]] = m_wdata[7:0];
      if (!(m_size[3] | m_size[2])) begin
        mem[m_addr[8:0] + 9'd1] = m_wdata[15:8];
        if (!(m_size[1] | m_size[0])) begin
          mem[m_addr[8:0] + 9'd2] = m_wdata[23:16];
          mem[m_addr[8:0] + 9'd3] = m_wdata[31:24];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // monitor: every done pulse is matched against the oldest expectation
  initial forever begin
    @(negedge clk);
    if (done[0] && done[1]) chk("done_both", 32'(done), 32'(0));
    else if (done != 0) begin
      int p;
      p = done[1] ? 1 : 0;
      if (sb.size() == 0) chk("unexpected_done", 32'(p + 1), 32'(0));
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_port", 32'(p), 32'(e.p));
        chk("done_err", 32'(err[p]), 32'(e.e));
        chk("done_rdata", rdata[p], e.rd);
      end
    end
    if ((err & ~done) != 0) chk("err_without_done", 32'(err), 32'(0));
  end

  task automatic access(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic e, input logic [31:0] rv);
    int n, k, rc, wc;
    if (!w && !e) shadow[p] = rv;
    sb.push_back('{p, e, shadow[p]});
    we[p] = w; addr[p] = a; wdata[p] = d; size[p] = s; req[p] = 1;
    n = 0;
    while (!gnt[p] && n < 20) begin step(); n++; end
    chk("gnt_seen", 32'(gnt[p]), 32'(1));
    req[p] = 0;
    chk("setup_strobes", 32'({m_read, m_write}), 32'(0));
    chk("setup_wen", 32'(m_wen), 32'(w));
    chk("setup_addr", m_addr, a);
    k = 0; rc = 0; wc = 0;
    do begin
      step();
      k++;
      rc += 32'(m_read);
      wc += 32'(m_write);
    end while (!done[p] && k < 20);
    chk("done_latency", 32'(k), e ? 32'(1) : w ? 32'(2) : 32'(LAT + 1));
    chk("read_cycles", 32'(rc), (w || e) ? 32'(0) : 32'(LAT));
    chk("write_cycles", 32'(wc), (w && !e) ? 32'(1) : 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    step();
    load = 0;
    step();
    rst = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_ctl", 32'({busy, m_read, m_write, m_wen, gnt, done, err}), 32'(0));
      chk("idle_data", m_addr | m_wdata | {28'b0, m_size} | rdata[0] | rdata[1], 32'(0));
    end
    access(0, 0, 32'h40, 0, 4'b0000, 0, 32'hDEADBEEF);
    access(1, 1, 32'h101, 32'hA5, 4'b1000, 0, 0);
    chk("mem_byte_write", 32'(mem[9'h101]), 32'hA5);
    chk("mem_byte_neighbour", 32'(mem[9'h102]), 32'h00);
    access(1, 0, 32'h101, 0, 4'b1000, 0, 32'hFFFFFFA5);
    access(1, 0, 32'h101, 0, 4'b0100, 0, 32'h000000A5);
    access(0, 0, 32'h100, 0, 4'b0000, 0, 32'h0000A500);
    access(0, 0, 32'h41, 0, 4'b1010, 0, 32'hFFFFFFBE);
    access(1, 0, 32'h42, 0, 4'b0001, 0, 32'h0000DEAD);
    access(0, 0, 32'h42, 0, 4'b0000, 1, 0);
    access(1, 1, 32'h43, 32'hBEEF, 4'b0010, 1, 0);
    chk("mis_mem43", 32'(mem[9'h043]), 32'hDE);
    chk("mis_mem44", 32'(mem[9'h044]), 32'h00);
    // reset during the write strobe
    we[1] = 1; addr[1] = 32'h50; wdata[1] = 32'h77; size[1] = 4'b1000; req[1] = 1;
    n = 0;
    while (!m_write && n < 20) begin step(); n++; end
    chk("mid_write_seen", 32'(m_write), 32'(1));
    #2 rst = 0;
    req = 0;
    #1;
    chk("async_drop", 32'({m_write, m_wen, m_read, gnt, done, err, busy}), 32'(0));
    chk("async_rdata", rdata[0] | rdata[1], 32'(0));
    #10 rst = 1;
    shadow = 0;
    repeat (3) step();
    chk("mid_mem_unchanged", 32'(mem[9'h050]), 32'h00);
    chk("mid_idle", 32'(busy), 32'(0));
    // continuous requests from both after reset
    we = 0; size = 0; addr[0] = 32'h40; addr[1] = 32'h80;
    shadow[0] = 32'hDEADBEEF; shadow[1] = 32'h12345678;
    for (int i = 0; i < 4; i++) sb.push_back('{i % 2, 1'b0, shadow[i % 2]});
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (gnt == 0 && n < 20) begin step(); n++; end
      chk("rr_order", 32'(gnt), (i % 2) ? 32'(2) : 32'(1));
      if (i == 3) req = 0;
      step();
    end
    repeat (6) step();
    chk("rr_idle", 32'(busy), 32'(0));
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
